// File: rtl/cv32e40p_ex_wb_pipeline.sv
// EX->WB stage: registers regfile writeback for finished instructions and parks loads
// until the LSU has returned every beat; also counts retirements and flags stray rvalids.
module cv32e40p_ex_wb_pipeline #(
  parameter int REG_ADDR_WIDTH   = 6,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_valid_i,
  input  logic                        regfile_we_ex_i,
  input  logic [REG_ADDR_WIDTH-1:0]   regfile_waddr_ex_i,
  input  logic [31:0]                 regfile_wdata_ex_i,
  input  logic                        data_req_ex_i,
  input  logic                        data_we_ex_i,
  input  logic                        data_misaligned_ex_i,
  input  logic                        lsu_rvalid_i,
  input  logic [31:0]                 lsu_rdata_i,
  input  logic                        flush_i,
  output logic                        wb_ready_o,
  output logic                        regfile_we_wb_o,
  output logic [REG_ADDR_WIDTH-1:0]   regfile_waddr_wb_o,
  output logic [31:0]                 regfile_wdata_wb_o,
  output logic                        wb_valid_o,
  output logic                        load_pending_o,
  output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_o,
  output logic                        spurious_rvalid_o
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  localparam logic [RETIRE_CNT_WIDTH-1:0] CNT_ONE = RETIRE_CNT_WIDTH'(1);

  state_e                      state_q;
  logic [1:0]                  beats_q;
  logic                        ld_we_q;
  logic [REG_ADDR_WIDTH-1:0]   ld_waddr_q;
  logic                        rf_we_q;
  logic [REG_ADDR_WIDTH-1:0]   rf_waddr_q;
  logic [31:0]                 rf_wdata_q;
  logic                        wb_valid_q;
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q;
  logic                        spurious_q;

  logic capture;
  logic is_load;

  assign wb_ready_o = (state_q == IDLE);
  assign capture    = ex_valid_i & wb_ready_o;
  assign is_load    = data_req_ex_i & ~data_we_ex_i;

  // NOTE: every register in this block is updated with <= so all of them sample the
  // pre-edge values; a blocking assignment here would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beats_q      <= 2'd0;
      ld_we_q      <= 1'b0;
      ld_waddr_q   <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      wb_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
      spurious_q   <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;

      // Nothing is outstanding in IDLE, so any response there is unexpected.
      if (lsu_rvalid_i && state_q == IDLE) spurious_q <= 1'b1;

      if (flush_i) begin
        state_q <= IDLE;
        beats_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (capture) begin
              if (is_load) begin
                ld_we_q    <= regfile_we_ex_i;
                ld_waddr_q <= regfile_waddr_ex_i;
                beats_q    <= data_misaligned_ex_i ? 2'd2 : 2'd1;
                state_q    <= WAIT_LOAD;
              end else begin
                wb_valid_q   <= 1'b1;
                retire_cnt_q <= retire_cnt_q + CNT_ONE;
                // Stores never write the regfile even if EX left its we set.
                if (regfile_we_ex_i && !data_req_ex_i) begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= regfile_waddr_ex_i;
                  rf_wdata_q <= regfile_wdata_ex_i;
                end
              end
            end
          end
          WAIT_LOAD: begin
            if (lsu_rvalid_i) begin
              beats_q <= beats_q - 2'd1;
              if (beats_q == 2'd1) begin
                state_q      <= IDLE;
                wb_valid_q   <= 1'b1;
                retire_cnt_q <= retire_cnt_q + CNT_ONE;
                rf_we_q      <= ld_we_q;
                rf_waddr_q   <= ld_waddr_q;
                rf_wdata_q   <= lsu_rdata_i;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign regfile_we_wb_o    = rf_we_q;
  assign regfile_waddr_wb_o = rf_waddr_q;
  assign regfile_wdata_wb_o = rf_wdata_q;
  assign wb_valid_o         = wb_valid_q;
  assign load_pending_o     = (state_q == WAIT_LOAD);
  assign retire_cnt_o       = retire_cnt_q;
  assign spurious_rvalid_o  = spurious_q;

endmodule

// File: tb/tb_cv32e40p_ex_wb_pipeline.sv
// Randomized scoreboard bench for the EX->WB stage: the driver predicts each retirement,
// a separate monitor compares every cycle's writeback against the queue.
module tb_cv32e40p_ex_wb_pipeline;
  localparam int RAW = 6;
  localparam int RCW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid_i, regfile_we_ex_i, data_req_ex_i, data_we_ex_i, data_misaligned_ex_i;
  logic [RAW-1:0]   regfile_waddr_ex_i;
  logic [31:0]      regfile_wdata_ex_i, lsu_rdata_i;
  logic             lsu_rvalid_i, flush_i;
  logic             wb_ready_o, regfile_we_wb_o, wb_valid_o, load_pending_o, spurious_rvalid_o;
  logic [RAW-1:0]   regfile_waddr_wb_o;
  logic [31:0]      regfile_wdata_wb_o;
  logic [RCW-1:0]   retire_cnt_o;

  cv32e40p_ex_wb_pipeline #(.REG_ADDR_WIDTH(RAW), .RETIRE_CNT_WIDTH(RCW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .regfile_we_ex_i(regfile_we_ex_i),
    .regfile_waddr_ex_i(regfile_waddr_ex_i), .regfile_wdata_ex_i(regfile_wdata_ex_i),
    .data_req_ex_i(data_req_ex_i), .data_we_ex_i(data_we_ex_i),
    .data_misaligned_ex_i(data_misaligned_ex_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .flush_i(flush_i),
    .wb_ready_o(wb_ready_o), .regfile_we_wb_o(regfile_we_wb_o),
    .regfile_waddr_wb_o(regfile_waddr_wb_o), .regfile_wdata_wb_o(regfile_wdata_wb_o),
    .wb_valid_o(wb_valid_o), .load_pending_o(load_pending_o),
    .retire_cnt_o(retire_cnt_o), .spurious_rvalid_o(spurious_rvalid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             due;
    logic           we;
    logic [RAW-1:0] waddr;
    logic [31:0]    wdata;
  } wb_t;

  wb_t            exp_q[$];
  logic [RCW-1:0] exp_cnt;
  bit             mon_en = 1'b0;
  int             checks = 0;
  int             errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle either the head of the queue is due, or nothing may retire.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          wb_t e;
          e = exp_q.pop_front();
          exp_cnt = exp_cnt + 1'b1;
          check("wb_valid", 32'(wb_valid_o), 32'd1);
          check("regfile_we", 32'(regfile_we_wb_o), 32'(e.we));
          if (e.we) begin
            check("waddr", 32'(regfile_waddr_wb_o), 32'(e.waddr));
            check("wdata", regfile_wdata_wb_o, e.wdata);
          end
          check("retire_cnt", 32'(retire_cnt_o), 32'(exp_cnt));
        end else begin
          check("no_retire", 32'({wb_valid_o, regfile_we_wb_o}), 32'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    ex_valid_i = 0; regfile_we_ex_i = 0; regfile_waddr_ex_i = '0; regfile_wdata_ex_i = '0;
    data_req_ex_i = 0; data_we_ex_i = 0; data_misaligned_ex_i = 0;
    lsu_rvalid_i = 0; lsu_rdata_i = '0; flush_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    32'(wb_ready_o), 32'd1);
    check({tag, "_pending"},  32'(load_pending_o), 32'd0);
    check({tag, "_we"},       32'(regfile_we_wb_o), 32'd0);
    check({tag, "_waddr"},    32'(regfile_waddr_wb_o), 32'd0);
    check({tag, "_wdata"},    regfile_wdata_wb_o, 32'd0);
    check({tag, "_valid"},    32'(wb_valid_o), 32'd0);
    check({tag, "_cnt"},      32'(retire_cnt_o), 32'd0);
    check({tag, "_spurious"}, 32'(spurious_rvalid_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 0;
    idle_inputs();
    rst = 1;
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;
    mon_en = 1;
  endtask

  // Reference model state: is a load outstanding, and how many responses remain.
  bit             m_wait;
  int             m_beats;
  logic           m_ld_we;
  logic [RAW-1:0] m_ld_addr;

  initial begin
    int kind;
    rst = 1;
    idle_inputs();
    m_wait = 0;
    do_reset();

    // Random traffic: rvalid only arrives while a load is outstanding.
    for (int i = 0; i < 3000; i++) begin
      if (i != 0) @(negedge clk);
      check("ready", 32'(wb_ready_o), 32'(!m_wait));
      check("pending", 32'(load_pending_o), 32'(m_wait));
      kind                 = $urandom_range(0, 4);
      ex_valid_i           = ($urandom_range(0, 2) != 0);
      regfile_waddr_ex_i   = RAW'($urandom);
      regfile_wdata_ex_i   = $urandom;
      data_req_ex_i        = (kind >= 2);
      data_we_ex_i         = (kind == 2);
      data_misaligned_ex_i = (kind == 4) ? 1'b1 : (kind < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      regfile_we_ex_i      = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 :
                             (kind == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      lsu_rvalid_i         = m_wait && ($urandom_range(0, 2) == 0);
      lsu_rdata_i          = $urandom;
      flush_i              = ($urandom_range(0, 40) == 0);

      if (flush_i) begin
        m_wait = 0;
      end else if (!m_wait && ex_valid_i) begin
        if (kind >= 3) begin
          m_wait    = 1;
          m_beats   = (kind == 4) ? 2 : 1;
          m_ld_we   = regfile_we_ex_i;
          m_ld_addr = regfile_waddr_ex_i;
        end else begin
          exp_q.push_back('{cyc + 1, (kind == 0), regfile_waddr_ex_i, regfile_wdata_ex_i});
        end
      end else if (m_wait && lsu_rvalid_i) begin
        m_beats--;
        if (m_beats == 0) begin
          exp_q.push_back('{cyc + 1, m_ld_we, m_ld_addr, lsu_rdata_i});
          m_wait = 0;
        end
      end
    end

    // Drain any outstanding load with back-to-back responses (at most two needed).
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      if (m_wait) begin
        lsu_rvalid_i = 1;
        lsu_rdata_i  = $urandom;
        m_beats--;
        if (m_beats == 0) begin
          exp_q.push_back('{cyc + 1, m_ld_we, m_ld_addr, lsu_rdata_i});
          m_wait = 0;
        end
      end
    end
    @(negedge clk); idle_inputs();
    @(negedge clk); @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("no_spurious_yet", 32'(spurious_rvalid_o), 32'd0);
    check("ready_after_drain", 32'(wb_ready_o), 32'd1);

    // Load pending, flush, then a response: no retire, sticky spurious flag, ready again.
    @(negedge clk);
    ex_valid_i = 1; data_req_ex_i = 1; regfile_we_ex_i = 1; regfile_waddr_ex_i = 6'd9;
    @(negedge clk);
    idle_inputs();
    check("flush_pending", 32'(load_pending_o), 32'd1);
    flush_i = 1;
    @(negedge clk);
    idle_inputs();
    lsu_rvalid_i = 1; lsu_rdata_i = 32'hCAFE_0001;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("flush_spurious", 32'(spurious_rvalid_o), 32'd1);
    check("flush_ready", 32'(wb_ready_o), 32'd1);

    // Reset while a load waits and its response arrives in the same cycle.
    ex_valid_i = 1; data_req_ex_i = 1; regfile_we_ex_i = 1; regfile_waddr_ex_i = 6'd7;
    @(negedge clk);
    idle_inputs();
    mon_en = 0;
    rst = 1; lsu_rvalid_i = 1; lsu_rdata_i = 32'h0000_1234;
    @(posedge clk); #1;
    check_reset_outputs("rst_in_wait");
    @(negedge clk);
    idle_inputs();
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
